// File: rtl/goe_nport.sv
// goe_nport: group output engine steering 134-bit packets to PORT_NUM output ports,
// with a drop path, per-port/drop/error statistics, and optional broadcast (GOE_BCAST_EN).
module goe_nport #(
  parameter int PORT_NUM = 4,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_goe_data_wr,
  input  logic [133:0]              in_goe_data,
  input  logic                      in_goe_valid_wr,
  input  logic                      in_goe_valid,
  output logic [PORT_NUM-1:0]       pktout_data_wr,
  output logic [134*PORT_NUM-1:0]   pktout_data,
  output logic [PORT_NUM-1:0]       pktout_data_valid_wr,
  output logic [PORT_NUM-1:0]       pktout_data_valid,
  output logic [CNT_W*PORT_NUM-1:0] port_pkt_cnt,
  output logic [CNT_W-1:0]          drop_pkt_cnt,
  output logic [CNT_W-1:0]          err_cnt
);

  typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

  state_t              state_q, state_d;
  logic [PORT_NUM-1:0] mask_q, mask_d;

  logic [1:0]          flags;
  logic [5:0]          port_sel;
  logic                is_head, is_tail, in_range, bcast;
  logic [PORT_NUM-1:0] dec_mask;

  logic [PORT_NUM-1:0] fwd_mask, vld_mask, cnt_inc;
  logic                drop_inc, err_inc;

  logic [PORT_NUM-1:0] wr_q, vwr_q, v_q;
  logic [133:0]        data_q [PORT_NUM];
  logic [CNT_W-1:0]    cnt_q  [PORT_NUM];
  logic [CNT_W-1:0]    drop_q, err_q;

  assign flags    = in_goe_data[133:132];
  assign port_sel = in_goe_data[117:112];
  assign is_head  = in_goe_data_wr && (flags == 2'b01);
  assign is_tail  = in_goe_data_wr && (flags == 2'b10);
  // Full 6-bit zero-extended compare, so p=0 maps to port 0 with no width tricks.
  assign in_range = {1'b0, port_sel} < 7'(PORT_NUM);

`ifdef GOE_BCAST_EN
  assign bcast = (port_sel == 6'h3F);
`else
  assign bcast = 1'b0;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    dec_mask = '0;
    for (int i = 0; i < PORT_NUM; i++) dec_mask[i] = (port_sel == 6'(i));
    if (bcast) dec_mask = '1;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      state_q <= IDLE;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
    end
  end

  // Next-state: a head always re-decodes, a tail closes any open packet.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    if (is_head) begin
      if (in_range || bcast) begin
        state_d = FWD;
        mask_d  = dec_mask;
      end else begin
        state_d = DROP;
        mask_d  = '0;
      end
    end else if (is_tail && state_q != IDLE) begin
      state_d = IDLE;
      mask_d  = '0;
    end
  end

  // Output decode: which ports receive this cycle's word/strobe, and counter events.
  always_comb begin
    fwd_mask = '0;
    vld_mask = '0;
    cnt_inc  = '0;
    drop_inc = 1'b0;
    err_inc  = 1'b0;
    if (is_head) begin
      fwd_mask = dec_mask;
      err_inc  = (state_q != IDLE);
    end else if (in_goe_data_wr) begin
      unique case (state_q)
        IDLE: err_inc = 1'b1;
        FWD: begin
          fwd_mask = mask_q;
          if (is_tail) cnt_inc = mask_q;
        end
        DROP:    drop_inc = is_tail;
        default: ;
      endcase
    end
    if (in_goe_valid_wr && state_q == FWD && !is_head) vld_mask = mask_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the per-port data and counter arrays are reset too; every output must read 0 in reset.
    if (!rst_n) begin
      wr_q   <= '0;
      vwr_q  <= '0;
      v_q    <= '0;
      drop_q <= '0;
      err_q  <= '0;
      for (int i = 0; i < PORT_NUM; i++) begin
        data_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      wr_q  <= fwd_mask;
      vwr_q <= vld_mask;
      v_q   <= vld_mask & {PORT_NUM{in_goe_valid}};
      for (int i = 0; i < PORT_NUM; i++) begin
        data_q[i] <= fwd_mask[i] ? in_goe_data : '0;
        if (cnt_inc[i]) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
      end
      if (drop_inc) drop_q <= drop_q + CNT_W'(1);
      if (err_inc)  err_q  <= err_q + CNT_W'(1);
    end
  end

  for (genvar g = 0; g < PORT_NUM; g++) begin : g_pack
    assign pktout_data[134*g +: 134]    = data_q[g];
    assign port_pkt_cnt[CNT_W*g +: CNT_W] = cnt_q[g];
  end

  assign pktout_data_wr       = wr_q;
  assign pktout_data_valid_wr = vwr_q;
  assign pktout_data_valid    = v_q;
  assign drop_pkt_cnt         = drop_q;
  assign err_cnt              = err_q;

endmodule

// File: tb/tb_goe_nport.sv
// tb_goe_nport: directed plus randomized stimulus for goe_nport (PORT_NUM=4),
// checked against a packet-level reference model.
module tb_goe_nport;
  localparam int NP = 4;
  localparam int CW = 16;
`ifdef GOE_BCAST_EN
  localparam bit BCAST = 1'b1;
`else
  localparam bit BCAST = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_goe_data_wr = 1'b0;
  logic [133:0]      in_goe_data = '0;
  logic              in_goe_valid_wr = 1'b0;
  logic              in_goe_valid = 1'b0;
  logic [NP-1:0]     pktout_data_wr;
  logic [134*NP-1:0] pktout_data;
  logic [NP-1:0]     pktout_data_valid_wr;
  logic [NP-1:0]     pktout_data_valid;
  logic [CW*NP-1:0]  port_pkt_cnt;
  logic [CW-1:0]     drop_pkt_cnt;
  logic [CW-1:0]     err_cnt;

  goe_nport #(.PORT_NUM(NP), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_goe_data_wr(in_goe_data_wr), .in_goe_data(in_goe_data),
    .in_goe_valid_wr(in_goe_valid_wr), .in_goe_valid(in_goe_valid),
    .pktout_data_wr(pktout_data_wr), .pktout_data(pktout_data),
    .pktout_data_valid_wr(pktout_data_valid_wr), .pktout_data_valid(pktout_data_valid),
    .port_pkt_cnt(port_pkt_cnt), .drop_pkt_cnt(drop_pkt_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: packet-level view (which ports own the open packet, or dropping).
  logic [NP-1:0] m_open;
  bit            m_drop;
  logic [CW-1:0] m_cnt [NP];
  logic [CW-1:0] m_dropc, m_errc;
  logic [133:0]  e_data [NP];
  logic [NP-1:0] e_wr, e_vwr, e_v;

  task automatic check(input string tag, input logic [133:0] obs, input logic [133:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_open = '0; m_drop = 1'b0; m_dropc = '0; m_errc = '0;
    e_wr = '0; e_vwr = '0; e_v = '0;
    for (int i = 0; i < NP; i++) begin m_cnt[i] = '0; e_data[i] = '0; end
  endtask

  task automatic model_step(input logic wr, input logic [133:0] d, input logic vwr, input logic v);
    logic [1:0] fl;
    int p;
    logic [NP-1:0] out;
    fl = d[133:132];
    p = int'(d[117:112]);
    out = '0;
    e_vwr = '0; e_v = '0;
    if (vwr && m_open != 0 && !(wr && fl == 2'b01)) begin
      e_vwr = m_open;
      e_v = v ? m_open : '0;
    end
    if (wr) begin
      if (fl == 2'b01) begin
        if (m_open != 0 || m_drop) m_errc++;
        m_open = '0; m_drop = 1'b0;
        if (p < NP) m_open = NP'(1) << p;
        else if (BCAST && p == 63) m_open = '1;
        else m_drop = 1'b1;
        out = m_open;
      end else if (m_open != 0) begin
        out = m_open;
        if (fl == 2'b10) begin
          for (int i = 0; i < NP; i++) if (m_open[i]) m_cnt[i]++;
          m_open = '0;
        end
      end else if (m_drop) begin
        if (fl == 2'b10) begin m_dropc++; m_drop = 1'b0; end
      end else begin
        m_errc++;
      end
    end
    e_wr = out;
    for (int i = 0; i < NP; i++) e_data[i] = out[i] ? d : '0;
  endtask

  task automatic check_all();
    for (int i = 0; i < NP; i++) begin
      check($sformatf("data%0d", i), pktout_data[134*i +: 134], e_data[i]);
      check($sformatf("wr%0d", i), 134'(pktout_data_wr[i]), 134'(e_wr[i]));
      check($sformatf("vwr%0d", i), 134'(pktout_data_valid_wr[i]), 134'(e_vwr[i]));
      check($sformatf("v%0d", i), 134'(pktout_data_valid[i]), 134'(e_v[i]));
      check($sformatf("cnt%0d", i), 134'(port_pkt_cnt[CW*i +: CW]), 134'(m_cnt[i]));
    end
    check("drop_cnt", 134'(drop_pkt_cnt), 134'(m_dropc));
    check("err_cnt", 134'(err_cnt), 134'(m_errc));
  endtask

  function automatic logic [133:0] mk(input logic [1:0] fl, input logic [5:0] p);
    logic [111:0] pl;
    pl = {$urandom(), $urandom(), $urandom(), 16'($urandom())};
    return {fl, 14'h0, p, pl};
  endfunction

  task automatic step(input logic wr, input logic [133:0] d, input logic vwr, input logic v);
    @(negedge clk);
    in_goe_data_wr = wr; in_goe_data = d; in_goe_valid_wr = vwr; in_goe_valid = v;
    model_step(wr, d, vwr, v);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle(); step(1'b0, '0, 1'b0, 1'b0); endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_goe_data_wr = 1'b0; in_goe_data = '0; in_goe_valid_wr = 1'b0; in_goe_valid = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pkt(input logic [5:0] p, input int mids, input logic v);
    step(1'b1, mk(2'b01, p), 1'b0, 1'b0);
    for (int k = 0; k < mids; k++) step(1'b1, mk(2'b11, 6'($urandom())), 1'b0, 1'b0);
    step(1'b1, mk(2'b10, 6'($urandom())), 1'b1, v);
  endtask

  initial begin
    model_reset();
    do_reset();

    // 3-word packet to port 2
    pkt(6'd2, 1, 1'b1);
    idle();
    check("s1_cnt2", 134'(port_pkt_cnt[CW*2 +: CW]), 134'(1));

    // back-to-back packets to port 0 then 3
    do_reset();
    pkt(6'd0, 2, 1'b1);
    pkt(6'd3, 1, 1'b0);
    idle();
    check("s2_cnt0", 134'(port_pkt_cnt[0 +: CW]), 134'(1));
    check("s2_cnt3", 134'(port_pkt_cnt[CW*3 +: CW]), 134'(1));

    // out-of-range port dropped, then port 1 delivered
    do_reset();
    pkt(6'd5, 2, 1'b1);
    pkt(6'd1, 0, 1'b1);
    idle();
    check("s3_drop", 134'(drop_pkt_cnt), 134'(1));
    check("s3_cnt1", 134'(port_pkt_cnt[CW*1 +: CW]), 134'(1));

    // missing tail: new head re-decodes
    do_reset();
    step(1'b1, mk(2'b01, 6'd1), 1'b0, 1'b0);
    step(1'b1, mk(2'b11, 6'd0), 1'b0, 1'b0);
    pkt(6'd0, 1, 1'b1);
    idle();
    check("s4_err", 134'(err_cnt), 134'(1));
    check("s4_cnt1", 134'(port_pkt_cnt[CW*1 +: CW]), 134'(0));
    check("s4_cnt0", 134'(port_pkt_cnt[0 +: CW]), 134'(1));

    // p = 6'h3F: broadcast or drop
    do_reset();
    pkt(6'h3F, 1, 1'b1);
    idle();
    check("s5_drop", 134'(drop_pkt_cnt), 134'(BCAST ? 0 : 1));
    for (int i = 0; i < NP; i++)
      check($sformatf("s5_cnt%0d", i), 134'(port_pkt_cnt[CW*i +: CW]), 134'(BCAST ? 1 : 0));

    // reset in mid-packet, stray words afterwards
    do_reset();
    step(1'b1, mk(2'b01, 6'd1), 1'b0, 1'b0);
    step(1'b1, mk(2'b11, 6'd0), 1'b0, 1'b0);
    do_reset();
    step(1'b1, mk(2'b11, 6'd0), 1'b0, 1'b0);
    step(1'b1, mk(2'b10, 6'd0), 1'b1, 1'b1);
    idle();
    check("s6_err", 134'(err_cnt), 134'(2));
    check("s6_wr", 134'(pktout_data_wr), 134'(0));

    // randomized traffic
    do_reset();
    for (int n = 0; n < 600; n++) begin
      logic wr, vwr, v;
      logic [1:0] fl;
      logic [5:0] p;
      int r;
      wr = ($urandom_range(0, 3) != 0);
      r = int'($urandom_range(0, 9));
      fl = (r < 2) ? 2'b01 : (r < 7) ? 2'b11 : (r < 9) ? 2'b10 : 2'b00;
      r = int'($urandom_range(0, 7));
      p = (r < 6) ? 6'(r) : (r == 6) ? 6'h3F : 6'($urandom_range(0, 63));
      vwr = wr && fl == 2'b10 && ($urandom_range(0, 3) != 0);
      v = 1'($urandom());
      step(wr, mk(fl, p), vwr, v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/goe_nport.md
# goe_nport

Parametrised group output engine: takes the 134-bit packet stream leaving the UM pipeline and steers each packet to one of `PORT_NUM` output ports using the 6-bit output-port field in the head word. It adds three things: a whole-packet drop path for out-of-range ports, per-port and drop/error statistics, and an optional broadcast mode. It sits at the end of the UM pipeline, after the action stage and in front of the per-port output queues.

## Interface
Parameters:
- `PORT_NUM`, 4: number of output ports, 1..32.
- `CNT_W`, 16: width of every statistics counter.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_goe_data_wr`  in  1  data word strobe.
- `in_goe_data`  in  134  word. [133:132] is 01 head, 11 middle, 10 tail. [117:112] is the output port, valid on the head word only.
- `in_goe_valid_wr`  in  1  packet-valid strobe, coincident with the tail word.
- `in_goe_valid`  in  1  packet-valid flag, sampled when `in_goe_valid_wr` is high.
- `pktout_data_wr`  out  PORT_NUM  per-port word strobe.
- `pktout_data`  out  134*PORT_NUM  per-port word; port i is in slice [134*i+133:134*i].
- `pktout_data_valid_wr`  out  PORT_NUM  per-port valid strobe.
- `pktout_data_valid`  out  PORT_NUM  per-port valid flag.
- `port_pkt_cnt`  out  CNT_W*PORT_NUM  per-port forwarded packet count (tails sent).
- `drop_pkt_cnt`  out  CNT_W  packets dropped.
- `err_cnt`  out  CNT_W  framing errors.

## Operation
- FSM states are IDLE, FWD and DROP. A registered `dst_mask[PORT_NUM-1:0]` holds the destination ports of the current packet.
- **IDLE**, on a head word (`wr`=1, flags 01): decode `p = in_goe_data[117:112]`.
  - If `p < PORT_NUM`: set `dst_mask = 1<<p`, forward the word, go to FWD.
  - If broadcast applies (see Configuration): set `dst_mask` to all ones, forward, go to FWD.
  - Otherwise: output nothing, go to DROP.
- **IDLE**, on a non-head word with `wr`=1: discard the word, `err_cnt`+1, stay in IDLE.
- **FWD**: every word with `wr`=1 is copied to all ports in `dst_mask`.
  - A tail word ends the packet: go to IDLE, and `port_pkt_cnt[i]`+1 for each i in `dst_mask`.
  - A head word arriving in FWD means the previous packet had no tail. `err_cnt`+1, then the word is re-decoded exactly as in IDLE. The old packet is not counted.
- **DROP**: consume words without output. On a tail word: `drop_pkt_cnt`+1, go to IDLE. A head word gets the same handling as in FWD.
- `wr`=0 cycles are ignored in every state. Gaps inside a packet are allowed.
- Valid routing:
  - `in_goe_valid_wr` is routed with the tail word. The selected ports get `pktout_data_valid_wr`=1 and `pktout_data_valid`=`in_goe_valid`.
  - In DROP, or when no packet is open, the strobe is swallowed.
- Ports not in `dst_mask` hold `pktout_data_wr`=0, `pktout_data_valid_wr`=0, `pktout_data_valid`=0, and data=0.
- Counters wrap modulo 2^CNT_W.

## Timing
- Latency is 1 cycle from an input word to the output word. Every output is registered.
- Throughput is one word per cycle. There is no backpressure, and downstream must accept every word.
- Reset: all outputs 0, all counters 0, state IDLE, `dst_mask` 0. Reset is applied asynchronously.
- A reset in the middle of a packet abandons it. Later words are handled per the IDLE rules and counted in `err_cnt` until the next head.
- Counter updates are visible 1 cycle after the tail word, in the same cycle the tail appears on the output.
- A head with `p=0` must reach port 0. In the old block, decoding `6'b1` as port 1 relied on width extension. Here the comparison is done on the full 6 bits, zero-extended.

## Configuration
- `GOE_BCAST_EN` defined: a head word with `p == 6'h3F` is broadcast to all `PORT_NUM` ports. That covers data, valid and `port_pkt_cnt` of every port.
- `GOE_BCAST_EN` not defined: `p == 6'h3F` is out of range and the packet is dropped. No broadcast logic is built.

## Test plan
All scenarios use `PORT_NUM`=4.
- Reset, then a 3-word packet to port 2 (head p=2, middle, tail with valid_wr=1, valid=1). Required: the packet appears only on port 2, 1 cycle later. `pktout_data_valid_wr[2]` pulses with the tail. `port_pkt_cnt[2]`=1. All other ports stay 0.
- Back-to-back packets to port 0 then port 3, with no idle cycle between them. Required: both are delivered, ports 0 and 3 each count 1, and nothing leaks across ports.
- Head with p=5, then a 4-word packet. Required: no output on any port, `drop_pkt_cnt`=1. A following packet to port 1 is delivered normally.
- Head p=1, middle, then a head p=0 with no tail in between. Required: `err_cnt`=1. The new packet goes to port 0. `port_pkt_cnt[1]` stays 0.
- Head p=6'h3F. With `GOE_BCAST_EN`: all 4 ports carry identical words and each `port_pkt_cnt` is 1. Without it: `drop_pkt_cnt`=1 and no output.
- Assert `rst_n` low in the middle of a packet, then send the remaining middle and tail words. Required: outputs are 0 during reset. Afterwards the stray words are discarded, `err_cnt`=2, and there is no output.
